// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: shared timing constants for the 480x272 RGB panel.
//   Holds the default horizontal/vertical segment lengths, the derived line
//   and frame totals, the coordinate width, the colour struct and a small
//   window-decode helper. The control module may reuse these for placement.
package lcd_timing_pkg;

    localparam int COORD_W = 11;

    localparam int H_SYNC_DEF  = 41;
    localparam int H_BACK_DEF  = 2;
    localparam int H_DISP_DEF  = 480;
    localparam int H_FRONT_DEF = 2;
    localparam int V_SYNC_DEF  = 10;
    localparam int V_BACK_DEF  = 2;
    localparam int V_DISP_DEF  = 272;
    localparam int V_FRONT_DEF = 2;

    localparam int H_TOTAL_DEF = H_SYNC_DEF + H_BACK_DEF + H_DISP_DEF + H_FRONT_DEF;
    localparam int V_TOTAL_DEF = V_SYNC_DEF + V_BACK_DEF + V_DISP_DEF + V_FRONT_DEF;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // True when c lies in the inclusive window [lo, hi].
    function automatic logic in_window(coord_t c, coord_t lo, coord_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/lcd_sync_module_if.sv
// lcd_sync_module_if: pixel-coordinate link between lcd_sync_module (master)
//   and lcd_control_module (slave).
//   master: drives ready_sig, column_addr_sig, row_addr_sig; reads colour.
//   slave : reads coordinates; returns red_sig/green_sig/blue_sig.
interface lcd_sync_module_if;
    import lcd_timing_pkg::*;

    logic       ready_sig;
    coord_t     column_addr_sig;
    coord_t     row_addr_sig;
    logic [7:0] red_sig;
    logic [7:0] green_sig;
    logic [7:0] blue_sig;

    modport master (
        output ready_sig, column_addr_sig, row_addr_sig,
        input  red_sig, green_sig, blue_sig
    );

    modport slave (
        input  ready_sig, column_addr_sig, row_addr_sig,
        output red_sig, green_sig, blue_sig
    );

endinterface

// File: rtl/lcd_delay_line.sv
// lcd_delay_line: DEPTH-stage register delay line of WIDTH bits.
//   clk  : clock
//   rst  : asynchronous active-high reset, clears every stage to 0
//   din  : input word
//   dout : din delayed by DEPTH clocks
module lcd_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= pipe_d;
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/lcd_sync_module.sv
// lcd_sync_module: timing generator and panel driver for the 480x272 LCD.
//   clk, rst   : pixel clock, asynchronous active-high reset
//   px         : coordinate/colour link (master side) to lcd_control_module
//   frame_done : one-cycle pulse on the last clock of each frame
//   lcd_hsync, lcd_vsync, lcd_de : panel syncs and data enable, delayed
//                PIPE_DELAY clocks to line up with the colour pipeline
//   lcd_r/g/b  : registered colour, forced to 0 outside the delayed DE
module lcd_sync_module
    import lcd_timing_pkg::*;
#(
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int H_DISP     = H_DISP_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int V_DISP     = V_DISP_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    lcd_sync_module_if.master px,
    output logic              frame_done,
    output logic              lcd_hsync,
    output logic              lcd_vsync,
    output logic              lcd_de,
    output logic [7:0]        lcd_r,
    output logic [7:0]        lcd_g,
    output logic [7:0]        lcd_b
);

    localparam int     H_TOTAL  = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int     V_TOTAL  = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT_LO = coord_t'(H_SYNC + H_BACK);
    localparam coord_t H_ACT_HI = coord_t'(H_SYNC + H_BACK + H_DISP - 1);
    localparam coord_t V_ACT_LO = coord_t'(V_SYNC + V_BACK);
    localparam coord_t V_ACT_HI = coord_t'(V_SYNC + V_BACK + V_DISP - 1);
    localparam coord_t H_SYNC_N = coord_t'(H_SYNC);
    localparam coord_t V_SYNC_N = coord_t'(V_SYNC);

    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;
    rgb_t   col_q, col_d;

    // v_cnt only moves on the line wrap; both wrap together at frame end.
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_comb col_d = {px.red_sig, px.green_sig, px.blue_sig};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            col_q   <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            col_q   <= col_d;
        end
    end

    // Decode straight off the counters: coordinates carry no extra latency.
    logic h_act, v_act, ready, hs_raw, vs_raw;

    assign h_act  = in_window(h_cnt_q, H_ACT_LO, H_ACT_HI);
    assign v_act  = in_window(v_cnt_q, V_ACT_LO, V_ACT_HI);
    assign ready  = h_act & v_act;
    assign hs_raw = h_cnt_q < H_SYNC_N;
    assign vs_raw = v_cnt_q < V_SYNC_N;

    assign px.ready_sig       = ready;
    assign px.column_addr_sig = ready ? h_cnt_q - H_ACT_LO : '0;
    assign px.row_addr_sig    = ready ? v_cnt_q - V_ACT_LO : '0;
    assign frame_done         = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    // Syncs and DE ride the same delay as the colour: control-module ROM
    // latency plus the colour register above.
    logic [2:0] dly_out;
    logic       hs_dly, vs_dly, de_dly;

    lcd_delay_line #(.WIDTH(3), .DEPTH(PIPE_DELAY)) u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  ({hs_raw, vs_raw, ready}),
        .dout (dly_out)
    );

    assign {hs_dly, vs_dly, de_dly} = dly_out;

    // Reset clears the delay line, so pins idle at the inactive level.
    assign lcd_hsync = hs_dly ^ ~SYNC_POL;
    assign lcd_vsync = vs_dly ^ ~SYNC_POL;
    assign lcd_de    = de_dly;
    assign lcd_r     = de_dly ? col_q.r : 8'h00;
    assign lcd_g     = de_dly ? col_q.g : 8'h00;
    assign lcd_b     = de_dly ? col_q.b : 8'h00;

endmodule

// File: tb/tb_lcd_sync_module.sv
// tb_lcd_sync_module: one full-size instance plus three reduced-timing
// instances (PIPE_DELAY 1/2/4, one with active-high syncs), all checked every
// cycle against an elapsed-clock frame model and a few literal timing points.
module tb_lcd_sync_module;
    import lcd_timing_pkg::*;

    typedef struct {
        int hs, hb, hd, hf, vs, vb, vd, vf, p;
        bit pol;
    } tp_t;

    typedef struct {
        logic       rdy;
        int         col, row;
        logic       fd, hs, vs, de;
        logic [7:0] r, g, b;
    } exp_t;

    localparam int S_HS = 4, S_HB = 2, S_HD = 8, S_HF = 2;
    localparam int S_VS = 2, S_VB = 1, S_VD = 4, S_VF = 1;

    logic        clk, rst;
    logic [23:0] cur_col;
    int          n, t_all, vectors, miscompares;
    tp_t         tp_def, tp_p1, tp_p2, tp_p4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lcd_sync_module_if if_def();
    lcd_sync_module_if if_p1();
    lcd_sync_module_if if_p2();
    lcd_sync_module_if if_p4();

    assign {if_def.red_sig, if_def.green_sig, if_def.blue_sig} = cur_col;
    assign {if_p1.red_sig,  if_p1.green_sig,  if_p1.blue_sig}  = cur_col;
    assign {if_p2.red_sig,  if_p2.green_sig,  if_p2.blue_sig}  = cur_col;
    assign {if_p4.red_sig,  if_p4.green_sig,  if_p4.blue_sig}  = cur_col;

    logic       fd_def, hs_def, vs_def, de_def;
    logic [7:0] r_def, g_def, b_def;
    logic       fd_p1, hs_p1, vs_p1, de_p1;
    logic [7:0] r_p1, g_p1, b_p1;
    logic       fd_p2, hs_p2, vs_p2, de_p2;
    logic [7:0] r_p2, g_p2, b_p2;
    logic       fd_p4, hs_p4, vs_p4, de_p4;
    logic [7:0] r_p4, g_p4, b_p4;

    lcd_sync_module u_def (
        .clk(clk), .rst(rst), .px(if_def), .frame_done(fd_def),
        .lcd_hsync(hs_def), .lcd_vsync(vs_def), .lcd_de(de_def),
        .lcd_r(r_def), .lcd_g(g_def), .lcd_b(b_def)
    );

    lcd_sync_module #(
        .H_SYNC(S_HS), .H_BACK(S_HB), .H_DISP(S_HD), .H_FRONT(S_HF),
        .V_SYNC(S_VS), .V_BACK(S_VB), .V_DISP(S_VD), .V_FRONT(S_VF),
        .SYNC_POL(1'b1), .PIPE_DELAY(1)
    ) u_p1 (
        .clk(clk), .rst(rst), .px(if_p1), .frame_done(fd_p1),
        .lcd_hsync(hs_p1), .lcd_vsync(vs_p1), .lcd_de(de_p1),
        .lcd_r(r_p1), .lcd_g(g_p1), .lcd_b(b_p1)
    );

    lcd_sync_module #(
        .H_SYNC(S_HS), .H_BACK(S_HB), .H_DISP(S_HD), .H_FRONT(S_HF),
        .V_SYNC(S_VS), .V_BACK(S_VB), .V_DISP(S_VD), .V_FRONT(S_VF),
        .SYNC_POL(1'b0), .PIPE_DELAY(2)
    ) u_p2 (
        .clk(clk), .rst(rst), .px(if_p2), .frame_done(fd_p2),
        .lcd_hsync(hs_p2), .lcd_vsync(vs_p2), .lcd_de(de_p2),
        .lcd_r(r_p2), .lcd_g(g_p2), .lcd_b(b_p2)
    );

    lcd_sync_module #(
        .H_SYNC(S_HS), .H_BACK(S_HB), .H_DISP(S_HD), .H_FRONT(S_HF),
        .V_SYNC(S_VS), .V_BACK(S_VB), .V_DISP(S_VD), .V_FRONT(S_VF),
        .SYNC_POL(1'b0), .PIPE_DELAY(4)
    ) u_p4 (
        .clk(clk), .rst(rst), .px(if_p4), .frame_done(fd_p4),
        .lcd_hsync(hs_p4), .lcd_vsync(vs_p4), .lcd_de(de_p4),
        .lcd_r(r_p4), .lcd_g(g_p4), .lcd_b(b_p4)
    );

    // Is elapsed-clock index k (within a frame) inside the active window?
    function automatic bit act_at(int k, tp_t t);
        int ht = t.hs + t.hb + t.hd + t.hf;
        int h  = k % ht;
        int v  = k / ht;
        return (h >= t.hs + t.hb) && (h < t.hs + t.hb + t.hd) &&
               (v >= t.vs + t.vb) && (v < t.vs + t.vb + t.vd);
    endfunction

    // Expected outputs after n clock edges since reset release.
    function automatic exp_t model(int nn, tp_t t, logic [23:0] col);
        exp_t e;
        int ht = t.hs + t.hb + t.hd + t.hf;
        int ft = ht * (t.vs + t.vb + t.vd + t.vf);
        int c  = nn % ft;
        int k;
        bit hsa = 1'b0, vsa = 1'b0;
        e.rdy = act_at(c, t);
        e.col = e.rdy ? (c % ht) - (t.hs + t.hb) : 0;
        e.row = e.rdy ? (c / ht) - (t.vs + t.vb) : 0;
        e.fd  = (c == ft - 1);
        e.de  = 1'b0;
        if (nn >= t.p) begin
            k    = (nn - t.p) % ft;
            e.de = act_at(k, t);
            hsa  = (k % ht) < t.hs;
            vsa  = (k / ht) < t.vs;
        end
        e.hs = t.pol ? hsa : !hsa;
        e.vs = t.pol ? vsa : !vsa;
        e.r  = e.de ? col[23:16] : 8'h00;
        e.g  = e.de ? col[15:8]  : 8'h00;
        e.b  = e.de ? col[7:0]   : 8'h00;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s n=%0d got=%0h exp=%0h", nm, n, got, exp);
        end
    endtask

    task automatic cmp_dut(input string tg, input tp_t t, input logic rdy,
                           input logic [10:0] col, input logic [10:0] row,
                           input logic fd, input logic hs, input logic vs,
                           input logic de, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b);
        exp_t e = model(n, t, cur_col);
        chk({tg, ".ready"}, 32'(rdy), 32'(e.rdy));
        chk({tg, ".col"},   32'(col), e.col);
        chk({tg, ".row"},   32'(row), e.row);
        chk({tg, ".fdone"}, 32'(fd),  32'(e.fd));
        chk({tg, ".hsync"}, 32'(hs),  32'(e.hs));
        chk({tg, ".vsync"}, 32'(vs),  32'(e.vs));
        chk({tg, ".de"},    32'(de),  32'(e.de));
        chk({tg, ".r"},     32'(r),   32'(e.r));
        chk({tg, ".g"},     32'(g),   32'(e.g));
        chk({tg, ".b"},     32'(b),   32'(e.b));
    endtask

    task automatic check_all();
        cmp_dut("def", tp_def, if_def.ready_sig, if_def.column_addr_sig, if_def.row_addr_sig,
                fd_def, hs_def, vs_def, de_def, r_def, g_def, b_def);
        cmp_dut("p1", tp_p1, if_p1.ready_sig, if_p1.column_addr_sig, if_p1.row_addr_sig,
                fd_p1, hs_p1, vs_p1, de_p1, r_p1, g_p1, b_p1);
        cmp_dut("p2", tp_p2, if_p2.ready_sig, if_p2.column_addr_sig, if_p2.row_addr_sig,
                fd_p2, hs_p2, vs_p2, de_p2, r_p2, g_p2, b_p2);
        cmp_dut("p4", tp_p4, if_p4.ready_sig, if_p4.column_addr_sig, if_p4.row_addr_sig,
                fd_p4, hs_p4, vs_p4, de_p4, r_p4, g_p4, b_p4);
        // Hand-computed timing points.
        case (n)
            1:    chk("lit.def_hsync_idle", 32'(hs_def), 1);
            2:    chk("lit.def_hsync_on",   32'(hs_def), 0);
            42:   chk("lit.def_hsync_last", 32'(hs_def), 0);
            43:   chk("lit.def_hsync_off",  32'(hs_def), 1);
            54: begin
                  chk("lit.p2_ready_first", 32'(if_p2.ready_sig), 1);
                  chk("lit.p1_de_pre",      32'(de_p1), 0);
                end
            55:   chk("lit.p1_de_rise",     32'(de_p1), 1);
            57:   chk("lit.p4_de_pre",      32'(de_p4), 0);
            58:   chk("lit.p4_de_rise",     32'(de_p4), 1);
            126:  chk("lit.p2_fdone_pre",   32'(fd_p2), 0);
            127:  chk("lit.p2_fdone",       32'(fd_p2), 1);
            5251: chk("lit.def_vsync_last", 32'(vs_def), 0);
            5252: chk("lit.def_vsync_off",  32'(vs_def), 1);
            6342: chk("lit.def_ready_pre",  32'(if_def.ready_sig), 0);
            6343: begin
                  chk("lit.def_ready_rise", 32'(if_def.ready_sig), 1);
                  chk("lit.def_col0",       32'(if_def.column_addr_sig), 0);
                  chk("lit.def_row0",       32'(if_def.row_addr_sig), 0);
                end
            6344: chk("lit.def_de_pre",     32'(de_def), 0);
            6345: begin
                  chk("lit.def_de_rise",    32'(de_def), 1);
                  chk("lit.def_r_at_de",    32'(r_def), 32'(cur_col[23:16]));
                end
            6822: begin
                  chk("lit.def_col479",     32'(if_def.column_addr_sig), 479);
                  chk("lit.def_ready_last", 32'(if_def.ready_sig), 1);
                end
            6823: chk("lit.def_ready_fall", 32'(if_def.ready_sig), 0);
            default: ;
        endcase
    endtask

    // Check at the falling edge, then drive reset and colour for the next edge.
    task automatic cycle(input bit rst_next);
        logic [7:0] t8;
        @(negedge clk);
        check_all();
        rst = rst_next;
        t_all++;
        t8 = t_all[7:0];
        cur_col = (t_all % 5 == 0) ? 24'hFFFFFF : {t8, ~t8, t8 ^ 8'hA5};
        if (rst) begin
            n = 0;
            #1 check_all();  // reset must act without waiting for an edge
        end
        @(posedge clk);
        if (rst) n = 0;
        else     n++;
    endtask

    initial begin
        tp_def = '{H_SYNC_DEF, H_BACK_DEF, H_DISP_DEF, H_FRONT_DEF,
                   V_SYNC_DEF, V_BACK_DEF, V_DISP_DEF, V_FRONT_DEF, 2, 1'b0};
        tp_p1  = '{S_HS, S_HB, S_HD, S_HF, S_VS, S_VB, S_VD, S_VF, 1, 1'b1};
        tp_p2  = '{S_HS, S_HB, S_HD, S_HF, S_VS, S_VB, S_VD, S_VF, 2, 1'b0};
        tp_p4  = '{S_HS, S_HB, S_HD, S_HF, S_VS, S_VB, S_VD, S_VF, 4, 1'b0};
        vectors = 0;
        miscompares = 0;
        n = 0;
        t_all = 0;
        cur_col = 24'h0;
        rst = 1'b1;

        repeat (3)    cycle(1'b1);
        repeat (6900) cycle(1'b0);
        // Mid-frame reset (default panel at line 13), held for 3 clocks.
        repeat (3)    cycle(1'b1);
        repeat (6850) cycle(1'b0);
        @(negedge clk);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
